// File: rtl/compfree_sort_core.sv
// Comparison-free sorting core: bit-plane candidate filtering over a valid-element mask,
// streaming winners in descending/ascending, unsigned/signed order with top-K and abort.
module compfree_sort_core #(
    parameter int unsigned ELEM_NUM = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = $clog2(ELEM_NUM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [ELEM_NUM*DATA_W-1:0]   load_data,
    input  logic                         mode_desc,
    input  logic                         mode_signed,
    input  logic [ADDR_W:0]              top_k,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_last,
    output logic                         busy
);

    localparam int unsigned KW = ADDR_W + 1;

    typedef enum logic {
        S_IDLE,
        S_SORT
    } state_t;

    state_t                             state_q, state_d;
    logic [ELEM_NUM-1:0]                evt_q, evt_d;
    logic [KW-1:0]                      cnt_q, cnt_d;
    logic [KW-1:0]                      k_q, k_d;
    logic                               desc_q, desc_d;
    logic                               sgn_q, sgn_d;
    logic [ELEM_NUM-1:0][DATA_W-1:0]    data_q, data_d;

    logic [ELEM_NUM-1:0]                cand;
    logic [ELEM_NUM-1:0]                hit;
    logic                               want;
    logic [ADDR_W-1:0]                  win;
    logic [KW-1:0]                      k_eff;
    logic                               fire;

    // Bit-plane filter MSB to LSB, then lowest-index priority encode so ties emit in index order.
    always_comb begin
        cand = evt_q;
        hit  = '0;
        want = 1'b0;
        for (int b = int'(DATA_W) - 1; b >= 0; b--) begin
            want = (b == int'(DATA_W) - 1) ? (desc_q ^ sgn_q) : desc_q;
            for (int i = 0; i < int'(ELEM_NUM); i++) begin
                hit[i] = cand[i] & (data_q[i][b] == want);
            end
            if (hit != '0) begin
                cand = hit;
            end
        end
        win = '0;
        for (int i = int'(ELEM_NUM) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win = ADDR_W'(i);
            end
        end
    end

    // Out-of-range or zero K means a full sort.
    always_comb begin
        k_eff = top_k;
        if ((top_k == '0) || (top_k > KW'(ELEM_NUM))) begin
            k_eff = KW'(ELEM_NUM);
        end
    end

    // Next-state and outputs; flush overrides load and emit.
    always_comb begin
        state_d    = state_q;
        evt_d      = evt_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        desc_d     = desc_q;
        sgn_d      = sgn_q;
        data_d     = data_q;
        load_ready = (state_q == S_IDLE);
        busy       = (state_q == S_SORT);
        out_valid  = (state_q == S_SORT);
        out_last   = (state_q == S_SORT) && (cnt_q == (k_q - KW'(1)));
        out_addr   = win;
        out_data   = data_q[win];
        fire       = out_valid & out_ready;

        if (flush) begin
            state_d = S_IDLE;
            evt_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_valid) begin
                        data_d  = load_data;
                        desc_d  = mode_desc;
                        sgn_d   = mode_signed;
                        k_d     = k_eff;
                        evt_d   = '1;
                        cnt_d   = '0;
                        state_d = S_SORT;
                    end
                end
                S_SORT: begin
                    if (fire) begin
                        evt_d[win] = 1'b0;
                        cnt_d      = cnt_q + KW'(1);
                        if (out_last) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            evt_q   <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            desc_q  <= 1'b0;
            sgn_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            desc_q  <= desc_d;
            sgn_q   <= sgn_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_compfree_sort_core.sv
// Bench for compfree_sort_core: directed vector table, hand-written abort/backpressure
// sequences, and randomized vectors against a stable-sort reference model.
module tb_compfree_sort_core;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int AW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic [N*W-1:0]    load_data = '0;
    logic              mode_desc = 1'b0;
    logic              mode_signed = 1'b0;
    logic [AW:0]       top_k = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [AW-1:0]     out_addr;
    logic [W-1:0]      out_data;
    logic              out_last;
    logic              busy;

    int checks = 0;
    int errors = 0;

    compfree_sort_core #(.ELEM_NUM(N), .DATA_W(W)) dut (
        .clk(clk), .rst(rst_n),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .mode_desc(mode_desc), .mode_signed(mode_signed), .top_k(top_k),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N*W-1:0]  d;
        logic            desc;
        logic            sgn;
        logic [AW:0]     k;
        logic [3:0]      n;
        logic [N*AW-1:0] ea;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: stable sort of elements by numeric value (negated for descending).
    task automatic model(input logic [N*W-1:0] d, input logic desc, input logic sgn,
                         input logic [AW:0] k, output logic [N*AW-1:0] ea, output int n);
        int idx [N];
        int key [N];
        int v, t, j;
        n = (k == 0 || k > N) ? N : int'(k);
        for (int i = 0; i < N; i++) begin
            idx[i] = i;
            v = sgn ? int'($signed(d[i*W +: W])) : int'(d[i*W +: W]);
            key[i] = desc ? -v : v;
        end
        for (int i = 1; i < N; i++) begin
            j = i;
            while (j > 0 && key[idx[j-1]] > key[idx[j]]) begin
                t = idx[j]; idx[j] = idx[j-1]; idx[j-1] = t;
                j--;
            end
        end
        ea = '0;
        for (int i = 0; i < N; i++) ea[i*AW +: AW] = AW'(idx[i]);
    endtask

    // Load one vector and drain n beats, with out_ready low bp_pct percent of cycles.
    task automatic run_sort(input logic [N*W-1:0] d, input logic desc, input logic sgn,
                            input logic [AW:0] k, input int n, input logic [N*AW-1:0] ea,
                            input int bp_pct);
        int beat, cyc, a;
        @(negedge clk);
        chk("load_ready_idle", 32'(load_ready), 32'd1);
        load_valid = 1'b1; load_data = d; mode_desc = desc; mode_signed = sgn; top_k = k;
        @(negedge clk);
        load_valid = 1'b0;
        beat = 0; cyc = 0;
        while (beat < n && cyc < 200) begin
            out_ready = ($urandom_range(0, 99) >= bp_pct);
            a = int'(ea[beat*AW +: AW]);
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk("out_addr", 32'(out_addr), 32'(a));
            chk("out_data", 32'(out_data), 32'(d[a*W +: W]));
            chk("out_last", 32'(out_last), 32'(beat == n - 1));
            if (out_ready) beat++;
            @(negedge clk);
            cyc++;
        end
        chk("beat_count", 32'(beat), 32'(n));
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_load_ready", 32'(load_ready), 32'd1);
    endtask

    logic [N*W-1:0]  rd;
    logic [N*AW-1:0] rea;
    int              rn;
    logic            rdesc, rsgn;
    logic [AW:0]     rk;

    initial begin
        tbl[0] = '{d: {8'd1,8'd17,8'd255,8'd0,8'd200,8'd17,8'd200,8'd3}, desc: 1'b1, sgn: 1'b0,
                   k: 4'd0, n: 4'd8, ea: {3'd4,3'd7,3'd0,3'd6,3'd2,3'd3,3'd1,3'd5}};
        tbl[1] = '{d: {8'd1,8'd17,8'd255,8'd0,8'd200,8'd17,8'd200,8'd3}, desc: 1'b0, sgn: 1'b0,
                   k: 4'd0, n: 4'd8, ea: {3'd5,3'd3,3'd1,3'd6,3'd2,3'd0,3'd7,3'd4}};
        tbl[2] = '{d: {8'h80,8'h7F,8'hFE,8'h01,8'h00,8'h80,8'h7F,8'hFF}, desc: 1'b1, sgn: 1'b1,
                   k: 4'd0, n: 4'd8, ea: {3'd7,3'd2,3'd5,3'd0,3'd3,3'd4,3'd6,3'd1}};
        tbl[3] = '{d: {8{8'h42}}, desc: 1'b1, sgn: 1'b0,
                   k: 4'd0, n: 4'd8, ea: {3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}};
        tbl[4] = '{d: {8'd1,8'd17,8'd255,8'd0,8'd200,8'd17,8'd200,8'd3}, desc: 1'b1, sgn: 1'b0,
                   k: 4'd1, n: 4'd1, ea: {21'd0,3'd5}};

        #12;
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++)
            run_sort(tbl[t].d, tbl[t].desc, tbl[t].sgn, tbl[t].k, int'(tbl[t].n), tbl[t].ea, 0);

        // Top-3 with two cycles of backpressure on the first beat.
        @(negedge clk);
        load_valid = 1'b1; load_data = tbl[0].d; mode_desc = 1'b1; mode_signed = 1'b0; top_k = 4'd3;
        @(negedge clk);
        load_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            out_ready = (c == 2);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_addr", 32'(out_addr), 32'd5);
            chk("bp_data", 32'(out_data), 32'd255);
            chk("bp_last", 32'(out_last), 32'd0);
            @(negedge clk);
        end
        chk("bp_addr2", 32'(out_addr), 32'd1);
        chk("bp_last2", 32'(out_last), 32'd0);
        @(negedge clk);
        chk("bp_addr3", 32'(out_addr), 32'd3);
        chk("bp_last3", 32'(out_last), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_done_valid", 32'(out_valid), 32'd0);
        chk("bp_done_ready", 32'(load_ready), 32'd1);

        // Flush after two fires; a beat offered alongside flush is dropped.
        @(negedge clk);
        load_valid = 1'b1; load_data = tbl[0].d; top_k = 4'd0;
        @(negedge clk);
        load_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("fl_addr_pre", 32'(out_addr), 32'd3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_load_ready", 32'(load_ready), 32'd1);
        run_sort(tbl[0].d, 1'b1, 1'b0, 4'd0, 8, tbl[0].ea, 0);

        // Asynchronous reset mid-sort.
        @(negedge clk);
        load_valid = 1'b1; load_data = tbl[1].d; mode_desc = 1'b0;
        @(negedge clk);
        load_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_load_ready", 32'(load_ready), 32'd1);
        chk("ar_addr", 32'(out_addr), 32'd0);
        chk("ar_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("ar_idle_valid", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        run_sort(tbl[1].d, 1'b0, 1'b0, 4'd0, 8, tbl[1].ea, 0);

        // Randomized vectors, duplicate-heavy half the time.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++)
                rd[i*W +: W] = (r % 2 == 0) ? W'($urandom_range(0, 3) * 64 + $urandom_range(0, 1))
                                            : W'($urandom);
            rdesc = 1'($urandom);
            rsgn  = 1'($urandom);
            rk    = (AW+1)'($urandom_range(0, 15));
            model(rd, rdesc, rsgn, rk, rea, rn);
            run_sort(rd, rdesc, rsgn, rk, rn, rea, 30);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
